// File: rtl/find_bw_right_edge_if.sv
// Bus between the right-edge bandwidth finder and its controller: start request,
// the spectrum arrays in, and the crossing result out.
interface find_bw_right_edge_if #(
   parameter int ACCUM_WIDTH    = 16,
   parameter int FREQ_BIN_WIDTH = 9,
   parameter int NUM_ACCUMS     = 16,
   parameter int FRAC_WIDTH     = 8
);
   logic                      start_i;
   logic [ACCUM_WIDTH-1:0]    accumulator_val_i [NUM_ACCUMS];
   logic [FREQ_BIN_WIDTH-1:0] freq_bin_i        [NUM_ACCUMS];
   logic [FREQ_BIN_WIDTH-1:0] f1_o;
   logic [FREQ_BIN_WIDTH-1:0] f2_o;
   logic [ACCUM_WIDTH-1:0]    L1_o;
   logic [ACCUM_WIDTH-1:0]    L2_o;
   logic [FRAC_WIDTH-1:0]     frac_o;
   logic                      found_o;
   logic                      valid_o;
   logic                      busy_o;

   modport master (
      output start_i, accumulator_val_i, freq_bin_i,
      input  f1_o, f2_o, L1_o, L2_o, frac_o, found_o, valid_o, busy_o
   );

   modport slave (
      input  start_i, accumulator_val_i, freq_bin_i,
      output f1_o, f2_o, L1_o, L2_o, frac_o, found_o, valid_o, busy_o
   );
endinterface

// File: rtl/find_bw_right_edge.sv
// Right-edge occupied-bandwidth finder: scans from the spectrum centre upward, keeps the
// rightmost fall through -THRESHOLD_DB, then interpolates the crossing with a restoring divider.
module find_bw_right_edge #(
   parameter int ACCUM_WIDTH    = 16,
   parameter int FREQ_BIN_WIDTH = 9,
   parameter int THRESHOLD_DB   = 30,
   parameter int NUM_ACCUMS     = 16,
   parameter int FRAC_WIDTH     = 8
) (
   input logic                 clk_i,
   input logic                 rst_i,
   find_bw_right_edge_if.slave bus
);
   localparam int IW = $clog2(NUM_ACCUMS);
   localparam int CW = $clog2(FRAC_WIDTH + 1);
   localparam int DW = ACCUM_WIDTH + 2;

   localparam logic [IW-1:0]        IDX_FIRST = IW'(NUM_ACCUMS / 2 - 1);
   localparam logic [IW-1:0]        IDX_LAST  = IW'(NUM_ACCUMS - 2);
   localparam logic [CW-1:0]        CNT_LAST  = CW'(FRAC_WIDTH - 1);
   localparam logic signed [DW-1:0] THR       = DW'(THRESHOLD_DB);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DIV,
      ST_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [FREQ_BIN_WIDTH-1:0] f1_q, f1_d, f2_q, f2_d;
   logic [ACCUM_WIDTH-1:0]    l1_q, l1_d, l2_q, l2_d;
   logic [FRAC_WIDTH-1:0]     frac_q, frac_d;
   logic                      found_q, found_d;
   logic [DW-1:0]             rem_q, rem_d, den_q, den_d;
   logic [CW-1:0]             cnt_q, cnt_d;

   logic [ACCUM_WIDTH-1:0] pair_l1, pair_l2;
   logic                   crossing;
   logic [DW-1:0]          rem_shl;
   logic                   qbit;

   function automatic logic [DW-1:0] sext(input logic [ACCUM_WIDTH-1:0] v);
      return {{2{v[ACCUM_WIDTH-1]}}, v};
   endfunction

   // Compared at two extra bits so negating the threshold can never overflow.
   function automatic logic above_thr(input logic [ACCUM_WIDTH-1:0] v);
      return $signed(sext(v)) > -THR;
   endfunction

   assign pair_l1  = bus.accumulator_val_i[idx_q];
   assign pair_l2  = bus.accumulator_val_i[idx_q + IW'(1)];
   assign crossing = above_thr(pair_l1) && !above_thr(pair_l2);

   // Remainder stays <= den, so the doubled value always fits in DW unsigned bits.
   assign rem_shl = rem_q << 1;
   assign qbit    = (rem_shl >= den_q);

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
      state_d = state_q;
      idx_d   = idx_q;
      f1_d    = f1_q;
      f2_d    = f2_q;
      l1_d    = l1_q;
      l2_d    = l2_q;
      frac_d  = frac_q;
      found_d = found_q;
      rem_d   = rem_q;
      den_d   = den_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               state_d = ST_SCAN;
               idx_d   = IDX_FIRST;
               f1_d    = '0;
               f2_d    = '0;
               l1_d    = '0;
               l2_d    = '0;
               frac_d  = '0;
               found_d = 1'b0;
            end
         end
         ST_SCAN: begin
            if (crossing) begin
               f1_d    = bus.freq_bin_i[idx_q];
               f2_d    = bus.freq_bin_i[idx_q + IW'(1)];
               l1_d    = pair_l1;
               l2_d    = pair_l2;
               found_d = 1'b1;
            end
            idx_d = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
               if (found_d) begin
                  // Setup uses the _d values so a crossing on the last pair is included.
                  state_d = ST_DIV;
                  rem_d   = sext(l1_d) + THR;
                  den_d   = sext(l1_d) - sext(l2_d);
                  cnt_d   = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DIV: begin
            rem_d  = qbit ? (rem_shl - den_q) : rem_shl;
            frac_d = {frac_q[FRAC_WIDTH-2:0], qbit};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         f1_q    <= '0;
         f2_q    <= '0;
         l1_q    <= '0;
         l2_q    <= '0;
         frac_q  <= '0;
         found_q <= 1'b0;
         rem_q   <= '0;
         den_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         f1_q    <= f1_d;
         f2_q    <= f2_d;
         l1_q    <= l1_d;
         l2_q    <= l2_d;
         frac_q  <= frac_d;
         found_q <= found_d;
         rem_q   <= rem_d;
         den_q   <= den_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.f1_o    = f1_q;
   assign bus.f2_o    = f2_q;
   assign bus.L1_o    = l1_q;
   assign bus.L2_o    = l2_q;
   assign bus.frac_o  = frac_q;
   assign bus.found_o = found_q;
   assign bus.valid_o = (state_q == ST_DONE);
   assign bus.busy_o  = (state_q == ST_SCAN) || (state_q == ST_DIV);
endmodule

// File: doc/find_bw_right_edge.md
# find_bw_right_edge

Right-edge companion of the left-edge bandwidth search. Scans the dB-scaled accumulator bins outward from the spectrum centre toward the high-index end and keeps the rightmost threshold crossing, where power falls from above `-THRESHOLD_DB` to at or below it. For a found crossing it also computes a fractional bin offset by linear interpolation with a sequential restoring divider. Sits beside the left-edge finder in the occupied-bandwidth path and uses the same accumulator and frequency-bin arrays.

## Interface
- `ACCUM_WIDTH`, 16: width of each signed two's-complement dB accumulator value.
- `FREQ_BIN_WIDTH`, 9: width of each frequency-bin index.
- `THRESHOLD_DB`, 30: threshold magnitude. The effective threshold is `-THRESHOLD_DB` dB.
- `NUM_ACCUMS`, 16: number of bins. Must be a power of two, ≥4.
- `FRAC_WIDTH`, 8: width of the interpolated fraction.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: start request. Sampled only in IDLE.
- `accumulator_val_i[NUM_ACCUMS]` in ACCUM_WIDTH each: dB values. Must be held stable while `busy_o`=1.
- `freq_bin_i[NUM_ACCUMS]` in FREQ_BIN_WIDTH each: bin indices. Must be held stable while `busy_o`=1.
- `f1_o` out FREQ_BIN_WIDTH: inner (lower) bin of the crossing.
- `f2_o` out FREQ_BIN_WIDTH: outer (higher) bin of the crossing.
- `L1_o` out ACCUM_WIDTH: power at `f1_o`.
- `L2_o` out ACCUM_WIDTH: power at `f2_o`.
- `frac_o` out FRAC_WIDTH: crossing position from `f1_o` toward `f2_o`, in units of 2^-FRAC_WIDTH bin.
- `found_o` out 1: a crossing was found.
- `valid_o` out 1: one-cycle result strobe.
- `busy_o` out 1: high in SCAN and DIV.

## Operation
- "Above threshold" means `$signed(v) > -THRESHOLD_DB`.
- A pair `idx` is `(L1=acc[idx], L2=acc[idx+1])`. It is a crossing when L1 is above threshold and L2 is not.
- States:
  - IDLE → SCAN on `start_i`. On entry: `idx := NUM_ACCUMS/2-1`, all result registers cleared (`found_o`, `f1/f2/L1/L2/frac` = 0).
  - SCAN: evaluates one pair per cycle.
    - On a crossing, latch f1/f2/L1/L2 and set found. A later crossing overwrites the earlier one, so the rightmost crossing is kept.
    - `idx` increments by 1. After pair `NUM_ACCUMS-2` has been evaluated:
      - found → DIV.
      - not found → DONE.
  - DIV: restoring division over FRAC_WIDTH cycles, MSB first.
    - Setup: `num = L1 + THRESHOLD_DB`, `den = L1 - L2`, both computed at ACCUM_WIDTH+2 bits. Invariant: `0 < num ≤ den`.
    - Each cycle: `r := r<<1`. If `r ≥ den`, then `r -= den` and the quotient bit is 1; otherwise the bit is 0. Initial `r = num`.
    - Result: `frac = floor(num·2^F/den)`. When `num == den`, every bit is 1, so the result is 2^F-1. No separate saturation logic is needed.
    - → DONE after F iterations.
  - DONE: `valid_o`=1 for this one cycle; `start_i` is ignored. → IDLE.
- Output retention: result outputs are registered and hold their values after DONE until the next accepted start, which clears them.
- Bins left of index `NUM_ACCUMS/2-1` are never examined.
- `start_i` is ignored in SCAN, DIV and DONE.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Effect of `rst_i`: when asserted at any edge, including mid-SCAN or mid-DIV, the next cycle shows IDLE, all outputs 0, and any partial result is discarded.
- Start protocol: `start_i` is sampled at edge k.
  - SCAN occupies cycles k+1 … k+NUM_ACCUMS/2.
  - If found: DIV occupies the next FRAC_WIDTH cycles and `valid_o` is high in cycle k+NUM_ACCUMS/2+FRAC_WIDTH+1.
  - If not found: `valid_o` is high in cycle k+NUM_ACCUMS/2+1.
- `busy_o`: exactly SCAN plus DIV cycles.
- Earliest next start: the cycle after DONE.
- Default latency (N=16, F=8): 17 cycles if found, 9 if not.

## Test plan
All scenarios use defaults, with `freq_bin_i[i]=100+i`.
- Bins all -10 → `valid_o` at k+9; `found_o`=0; f1/f2/L1/L2/frac all 0; `busy_o` high for 8 cycles.
- acc[0..10]=-10, acc[11..15]=-50 → `valid_o` at k+17; `found_o`=1; `f1_o`=110, `f2_o`=111; `L1_o`=0xFFF6, `L2_o`=0xFFCE; num=20, den=40 gives `frac_o`=128.
- acc[0..9]=-10, acc[10]=-40, acc[11]=-20, acc[12..15]=-60 → rightmost crossing kept: `f1_o`=111, `f2_o`=112; num=10, den=40 gives `frac_o`=64.
- acc[0..12]=-20, acc[13..15]=-30 (L2 exactly at threshold) → `f1_o`=112, `f2_o`=113; num=den=10 gives `frac_o`=255.
- Scan-range boundaries:
  - Only crossing at idx 3 (acc[0..3]=-10, acc[4..15]=-50) → `found_o`=0.
  - Only crossing at idx 14 (acc[0..14]=-10, acc[15]=-50) → `found_o`=1, `f1_o`=114, `f2_o`=115.
- Scenario-2 data with `rst_i` asserted during DIV cycle 3 → all outputs 0 and `busy_o`=0 the next cycle, with no `valid_o`. `start_i` pulses while busy are ignored: the cycle count of a subsequent run is unchanged.
